mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage data-bus master; the store-side counterpart of the writeback load aligner.
- Turns register data into byte-lane write data plus byte enables for SB/SH/SW/SWL/SWR, and issues both loads and stores on the data bus with a req/ack handshake.
- Stalls the pipeline while a bus access is outstanding.
- Captures raw read data word-aligned, so writeback can perform load extraction.

Parameters:
- BUS_TIMEOUT, 0, cycles to wait for dbus_ack before aborting. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  instruction in MEM stage is valid
- mem_access_op  in  2  access op from the shared defines (M2R=load, R2M=store, others=no bus access)
- mem_access_sz  in  3  access size (BYTE, HALF, WORD, LEFT, RIGHT)
- addr_i  in  32  byte address
- data_i  in  32  rt register value (store source)
- exception_det  in  1  exception/flush for the current instruction
- busy_o  out  1  pipeline stall request
- done_o  out  1  one-cycle pulse: access finished
- mem_data_o  out  32  read word captured on ack
- addr_err_o  out  1  misaligned HALF/WORD access (AdEL/AdES source)
- bus_err_o  out  1  one-cycle pulse: timeout abort
- dbus_addr  out  32  word address {addr_i[31:2],2'b00}
- dbus_read  out  1  read strobe
- dbus_write  out  1  write strobe
- dbus_wrdata  out  32  lane-replicated write data
- dbus_byteenable  out  4  lane enables, bit n = byte n (little-endian)
- dbus_ack  in  1  bus completes the access this cycle

Behaviour:
- Reset (async) drives state=IDLE and clears all outputs and the counter: busy_o, done_o, bus_err_o, dbus_read, dbus_write = 0; dbus_addr, dbus_wrdata, mem_data_o = 0; dbus_byteenable = 0.
- Format rules, with a=addr_i[1:0]:
  - BYTE: wrdata={4{d[7:0]}}, be=4'b0001<<a.
  - HALF: wrdata={2{d[15:0]}}, be = a[1] ? 1100 : 0011; error if a[0]=1.
  - WORD: wrdata=d, be=1111; error if a!=0.
  - LEFT (SWL): wrdata=d>>((3-a)*8), be=4'b1111>>(3-a).
  - RIGHT (SWR): wrdata=d<<(a*8), be=(4'b1111<<a)[3:0].
  - Loads: be=1111; HALF/WORD alignment checks apply.
  - Undefined sizes: be=0000, no bus access.
- addr_err_o is combinational. It asserts in IDLE when req_valid & op in {M2R,R2M} & misaligned & !exception_det. It causes no bus access and no stall.
- accept = IDLE & req_valid & op in {M2R,R2M} & !exception_det & !addr_err & be!=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY on accept. At the same edge, register dbus_addr/wrdata/byteenable and set dbus_read (M2R) or dbus_write (R2M).
  - BUSY: outputs held stable. On dbus_ack: capture mem_data_o (read data if load; unchanged if store), drop strobes, go to DONE.
  - BUSY with BUS_TIMEOUT!=0 and counter==BUS_TIMEOUT-1 and no ack: drop strobes, mem_data_o=0, go to DONE with bus_err_o=1.
  - DONE: done_o=1 for exactly this cycle. No accept in this cycle, since the same instruction is still presented. Unconditionally go to IDLE.
- busy_o = accept | (state==BUSY), combinational. busy_o is low in DONE, and the pipeline advances at the end of DONE.
- Minimum latency: accept at cycle N, strobe at N+1, ack at N+1, done_o at N+2.
- exception_det rising while BUSY does not abort; the bus transaction must complete.
- A zero-wait ack is allowed. An ack outside BUSY is ignored.
- The counter resets on entry to BUSY and saturates; it is not used when BUS_TIMEOUT=0.
- rst mid-transaction: strobes drop immediately (async); the bus must tolerate abandonment.

Decomposition:
- ACCESS_OP_* and ACCESS_SZ_* come from the shared defines header. Add the FSM state encodings there as MAU_ST_* constants.
- Sub-module mem_store_fmt: purely combinational. Inputs: size, a, data_i, op. Outputs: wrdata, byteenable, misaligned.

Test Plan:
- SB with a=2, d=0x11223344 -> dbus_wrdata=0x44444444, be=0100, dbus_write high at N+1; ack at N+3 -> done_o at N+4; busy_o high N..N+3.
- SWL a=1, d=0xAABBCCDD -> wrdata=0x0000AABB, be=0011. SWR a=1 -> wrdata=0xBBCCDD00, be=1110.
- LW at 0x1004, ack same cycle as strobe with rddata=0xDEADBEEF -> dbus_addr=0x1004, be=1111, mem_data_o=0xDEADBEEF at done_o (cycle N+2).
- SH at 0x1001 -> addr_err_o=1, no strobe, busy_o=0. SW at 0x1002 -> addr_err_o=1.
- BUS_TIMEOUT=4, store with no ack -> strobe held 4 cycles, then bus_err_o and done_o pulse together, mem_data_o=0.
- rst asserted while BUSY -> dbus_write and busy_o low asynchronously; after release, a new SB completes normally. req_valid held through DONE is not re-issued.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared defines for the memory stage: access op / size encodings used by
// decode, MEM and writeback, plus the MEM bus-master FSM state encodings.
package mem_access_unit_pkg;

  // access op (2 bits)
  localparam logic [1:0] ACCESS_OP_NONE = 2'd0;
  localparam logic [1:0] ACCESS_OP_M2R  = 2'd1;  // load
  localparam logic [1:0] ACCESS_OP_R2M  = 2'd2;  // store
  localparam logic [1:0] ACCESS_OP_REG  = 2'd3;  // register-only, no bus access

  // access size (3 bits); encodings 5..7 are undefined
  localparam logic [2:0] ACCESS_SZ_BYTE  = 3'd0;
  localparam logic [2:0] ACCESS_SZ_HALF  = 3'd1;
  localparam logic [2:0] ACCESS_SZ_WORD  = 3'd2;
  localparam logic [2:0] ACCESS_SZ_LEFT  = 3'd3;  // SWL/LWL
  localparam logic [2:0] ACCESS_SZ_RIGHT = 3'd4;  // SWR/LWR

  // bus-master FSM states
  localparam logic [1:0] MAU_ST_IDLE = 2'd0;
  localparam logic [1:0] MAU_ST_BUSY = 2'd1;
  localparam logic [1:0] MAU_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = MAU_ST_IDLE,
    ST_BUSY = MAU_ST_BUSY,
    ST_DONE = MAU_ST_DONE
  } mau_state_e;

  // true for ops that touch the data bus
  function automatic logic is_bus_op(input logic [1:0] op);
    return (op == ACCESS_OP_M2R) || (op == ACCESS_OP_R2M);
  endfunction

endpackage

// File: rtl/mem_store_fmt.sv
// Store formatter: maps rt data and the low address bits onto little-endian
// byte lanes, producing lane-replicated write data and byte enables. Loads
// always request the full word (writeback extracts the bytes).
// Ports:
//   size       in  3   access size
//   a          in  2   addr[1:0]
//   data_i     in  32  rt value
//   op         in  2   access op
//   wrdata     out 32  lane-positioned write data
//   byteenable out 4   lane enables, 0 for undefined sizes
//   misaligned out 1   HALF with a[0]=1, or WORD with a!=0
module mem_store_fmt
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  a,
  input  logic [31:0] data_i,
  input  logic [1:0]  op,
  output logic [31:0] wrdata,
  output logic [3:0]  byteenable,
  output logic        misaligned
);

  logic [3:0] st_be;
  logic       sz_ok;

  always_comb begin
    wrdata     = '0;
    st_be      = 4'b0000;
    misaligned = 1'b0;
    sz_ok      = 1'b1;
    case (size)
      ACCESS_SZ_BYTE: begin
        wrdata = {4{data_i[7:0]}};
        st_be  = 4'b0001 << a;
      end
      ACCESS_SZ_HALF: begin
        wrdata     = {2{data_i[15:0]}};
        st_be      = a[1] ? 4'b1100 : 4'b0011;
        misaligned = a[0];
      end
      ACCESS_SZ_WORD: begin
        wrdata     = data_i;
        st_be      = 4'b1111;
        misaligned = (a != 2'd0);
      end
      // ~a == 3-a for a 2-bit address: SWL writes the top (a+1) bytes of rt
      // into the low lanes up to lane a.
      ACCESS_SZ_LEFT: begin
        wrdata = data_i >> {~a, 3'b000};
        st_be  = 4'b1111 >> ~a;
      end
      // SWR writes the low (4-a) bytes of rt into lanes a..3.
      ACCESS_SZ_RIGHT: begin
        wrdata = data_i << {a, 3'b000};
        st_be  = 4'b1111 << a;
      end
      default: sz_ok = 1'b0;
    endcase
    byteenable = (op == ACCESS_OP_M2R) ? (sz_ok ? 4'b1111 : 4'b0000) : st_be;
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-bus master. Formats stores, issues loads/stores with a
// req/ack handshake, stalls the pipeline while the access is outstanding
// and captures the raw read word for writeback.
// Ports:
//   clk, rst                  clock, async active-high reset
//   req_valid, mem_access_op, mem_access_sz, addr_i, data_i, exception_det
//                             MEM-stage instruction
//   busy_o                    stall request (accept or access in flight)
//   done_o / bus_err_o        one-cycle completion / timeout pulses
//   mem_data_o                read word captured on ack
//   addr_err_o                misaligned HALF/WORD (combinational)
//   dbus_*                    data bus master side; dbus_rddata/dbus_ack in
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int BUS_TIMEOUT = 0  // cycles to wait for ack; 0 = wait forever
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  mem_access_op,
  input  logic [2:0]  mem_access_sz,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        exception_det,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] mem_data_o,
  output logic        addr_err_o,
  output logic        bus_err_o,
  output logic [31:0] dbus_addr,
  output logic        dbus_read,
  output logic        dbus_write,
  output logic [31:0] dbus_wrdata,
  output logic [3:0]  dbus_byteenable,
  input  logic [31:0] dbus_rddata,
  input  logic        dbus_ack
);

  localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = '1;

  mau_state_e    state;
  logic [CW-1:0] cnt;

  logic [31:0] fmt_wrdata;
  logic [3:0]  fmt_be;
  logic        fmt_mis;
  logic        bus_req;
  logic        accept;
  logic        timeout_hit;

  mem_store_fmt u_fmt (
    .size       (mem_access_sz),
    .a          (addr_i[1:0]),
    .data_i     (data_i),
    .op         (mem_access_op),
    .wrdata     (fmt_wrdata),
    .byteenable (fmt_be),
    .misaligned (fmt_mis)
  );

  // Only a fresh instruction in IDLE can start or fault; in DONE the same
  // instruction is still presented and must not be re-issued.
  assign bus_req     = (state == ST_IDLE) && req_valid && is_bus_op(mem_access_op) && !exception_det;
  assign addr_err_o  = bus_req && fmt_mis;
  assign accept      = bus_req && !fmt_mis && (fmt_be != 4'b0000);
  assign busy_o      = accept || (state == ST_BUSY);
  assign timeout_hit = (BUS_TIMEOUT != 0) && (cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      done_o          <= 1'b0;
      bus_err_o       <= 1'b0;
      mem_data_o      <= '0;
      dbus_addr       <= '0;
      dbus_read       <= 1'b0;
      dbus_write      <= 1'b0;
      dbus_wrdata     <= '0;
      dbus_byteenable <= '0;
    end else begin
      done_o    <= 1'b0;
      bus_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dbus_addr       <= {addr_i[31:2], 2'b00};
            dbus_wrdata     <= fmt_wrdata;
            dbus_byteenable <= fmt_be;
            dbus_read       <= (mem_access_op == ACCESS_OP_M2R);
            dbus_write      <= (mem_access_op == ACCESS_OP_R2M);
            cnt             <= '0;
            state           <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // exception_det is ignored here: an issued access always completes.
          if (dbus_ack) begin
            if (dbus_read) mem_data_o <= dbus_rddata;
            dbus_read  <= 1'b0;
            dbus_write <= 1'b0;
            done_o     <= 1'b1;
            state      <= ST_DONE;
          end else if (timeout_hit) begin
            mem_data_o <= '0;
            dbus_read  <= 1'b0;
            dbus_write <= 1'b0;
            done_o     <= 1'b1;
            bus_err_o  <= 1'b1;
            state      <= ST_DONE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TO = 4;

  logic        clk = 0, rst = 1;
  logic        req_valid = 0, exception_det = 0, dbus_ack = 0;
  logic [1:0]  mem_access_op = ACCESS_OP_NONE;
  logic [2:0]  mem_access_sz = ACCESS_SZ_BYTE;
  logic [31:0] addr_i = 0, data_i = 0, dbus_rddata = 0;
  logic        busy_o, done_o, addr_err_o, bus_err_o, dbus_read, dbus_write;
  logic [31:0] mem_data_o, dbus_addr, dbus_wrdata;
  logic [3:0]  dbus_byteenable;

  mem_access_unit #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_access_op(mem_access_op),
    .mem_access_sz(mem_access_sz), .addr_i(addr_i), .data_i(data_i),
    .exception_det(exception_det), .busy_o(busy_o), .done_o(done_o),
    .mem_data_o(mem_data_o), .addr_err_o(addr_err_o), .bus_err_o(bus_err_o),
    .dbus_addr(dbus_addr), .dbus_read(dbus_read), .dbus_write(dbus_write),
    .dbus_wrdata(dbus_wrdata), .dbus_byteenable(dbus_byteenable),
    .dbus_rddata(dbus_rddata), .dbus_ack(dbus_ack)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // per-cycle expectations, written by the driver just after each edge
  logic        cmp_en = 0;
  logic        e_busy = 0, e_done = 0, e_berr = 0, e_rd = 0, e_wr = 0, e_aerr = 0;
  logic [31:0] e_addr = 0, e_wd = 0, m_mdata = 0;
  logic [3:0]  e_be = 0;

  // captured observations for literal pins
  logic [31:0] cap_wd;
  logic [3:0]  cap_be;
  logic        cap_aerr, cap_berr;
  int          lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (cmp_en) begin
    chk("busy_o", busy_o, e_busy);
    chk("done_o", done_o, e_done);
    chk("bus_err_o", bus_err_o, e_berr);
    chk("dbus_read", dbus_read, e_rd);
    chk("dbus_write", dbus_write, e_wr);
    chk("addr_err_o", addr_err_o, e_aerr);
    chk("mem_data_o", mem_data_o, m_mdata);
    if (e_rd || e_wr) begin
      chk("dbus_addr", dbus_addr, e_addr);
      chk("dbus_byteenable", dbus_byteenable, e_be);
    end
    if (e_wr) chk("dbus_wrdata", dbus_wrdata, e_wd);
  end

  // Lane-by-lane description of a store: which source byte lands in lane n.
  function automatic void fmt_model(input logic [2:0] sz, input int a, input logic [31:0] d,
                                    input bit load, output logic [31:0] wd,
                                    output logic [3:0] be, output bit mis);
    int src;
    bit defined;
    wd = 0; be = 0; mis = 0;
    defined = (sz <= ACCESS_SZ_RIGHT);
    for (int n = 0; n < 4; n++) begin
      src = -1;
      case (sz)
        ACCESS_SZ_BYTE:  begin src = 0; be[n] = (n == a); end
        ACCESS_SZ_HALF:  begin src = n % 2; be[n] = ((n / 2) == (a / 2)); end
        ACCESS_SZ_WORD:  begin src = n; be[n] = 1; end
        ACCESS_SZ_LEFT:  begin src = n + 3 - a; be[n] = (n <= a); end
        ACCESS_SZ_RIGHT: begin src = n - a; be[n] = (n >= a); end
        default: ;
      endcase
      if (src >= 0 && src <= 3) wd[n*8 +: 8] = d[src*8 +: 8];
    end
    if (sz == ACCESS_SZ_HALF) mis = (a % 2) != 0;
    if (sz == ACCESS_SZ_WORD) mis = (a != 0);
    if (load && defined) be = 4'b1111;
  endfunction

  task automatic idle_exp();
    e_busy = 0; e_done = 0; e_berr = 0; e_rd = 0; e_wr = 0; e_aerr = 0;
  endtask

  // One MEM-stage instruction. wt = strobe cycles before ack (-1: never).
  // exc_busy raises exception_det while the access is in flight.
  task automatic access(input logic [1:0] op, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input int wt, input logic [31:0] rd,
                        input bit exc, input bit exc_busy);
    logic [31:0] wd; logic [3:0] be; bit mis, ismem, acc, timed;
    int n0, i;
    fmt_model(sz, a[1:0], d, op == ACCESS_OP_M2R, wd, be, mis);
    ismem = (op == ACCESS_OP_M2R) || (op == ACCESS_OP_R2M);
    acc   = ismem && !exc && !mis && (be != 0);
    // request cycle
    req_valid = 1; mem_access_op = op; mem_access_sz = sz; addr_i = a; data_i = d;
    exception_det = exc; dbus_ack = 0;
    idle_exp(); e_busy = acc; e_aerr = ismem && mis && !exc;
    n0 = cyc;
    #1 cap_aerr = addr_err_o;
    @(posedge clk); #1;
    if (acc) begin
      i = 0; timed = 0;
      forever begin
        exception_det = exc_busy;
        e_busy = 1; e_aerr = 0;
        e_rd = (op == ACCESS_OP_M2R); e_wr = (op == ACCESS_OP_R2M);
        e_addr = {a[31:2], 2'b00}; e_be = be; e_wd = wd;
        if (i == 0) begin cap_wd = dbus_wrdata; cap_be = dbus_byteenable; end
        dbus_ack = (i == wt); dbus_rddata = rd;
        if (i == wt) break;
        if (i == TO - 1) begin timed = 1; break; end
        @(posedge clk); #1; i++;
      end
      @(posedge clk); #1;
      // DONE: instruction still presented, stray ack with junk data
      dbus_ack = 1; dbus_rddata = 32'hBAD0BAD0;
      idle_exp(); e_done = 1; e_berr = timed;
      if (timed) m_mdata = 0;
      else if (op == ACCESS_OP_M2R) m_mdata = rd;
      lat = cyc - n0; cap_berr = bus_err_o;
      @(posedge clk); #1;
    end
    req_valid = 0; dbus_ack = 0; exception_det = 0; idle_exp();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] twd; logic [3:0] tbe; bit tmis;
    cmp_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    // pin the lane model against hand-computed values
    fmt_model(ACCESS_SZ_BYTE, 2, 32'h11223344, 0, twd, tbe, tmis);
    chk("model_sb_wd", twd, 32'h44444444); chk("model_sb_be", tbe, 4'b0100);
    fmt_model(ACCESS_SZ_LEFT, 1, 32'hAABBCCDD, 0, twd, tbe, tmis);
    chk("model_swl_wd", twd, 32'h0000AABB); chk("model_swl_be", tbe, 4'b0011);
    fmt_model(ACCESS_SZ_RIGHT, 1, 32'hAABBCCDD, 0, twd, tbe, tmis);
    chk("model_swr_wd", twd, 32'hBBCCDD00); chk("model_swr_be", tbe, 4'b1110);

    // SB a=2, ack on third strobe cycle
    access(ACCESS_OP_R2M, ACCESS_SZ_BYTE, 32'h0000_0102, 32'h11223344, 2, 0, 0, 0);
    chk("sb_wd", cap_wd, 32'h44444444); chk("sb_be", cap_be, 4'b0100); chk("sb_lat", lat, 4);
    // SWL / SWR a=1
    access(ACCESS_OP_R2M, ACCESS_SZ_LEFT, 32'h0000_0201, 32'hAABBCCDD, 0, 0, 0, 0);
    chk("swl_wd", cap_wd, 32'h0000AABB); chk("swl_be", cap_be, 4'b0011);
    access(ACCESS_OP_R2M, ACCESS_SZ_RIGHT, 32'h0000_0201, 32'hAABBCCDD, 1, 0, 0, 0);
    chk("swr_wd", cap_wd, 32'hBBCCDD00); chk("swr_be", cap_be, 4'b1110);
    // LW, zero-wait ack
    access(ACCESS_OP_M2R, ACCESS_SZ_WORD, 32'h0000_1004, 0, 0, 32'hDEADBEEF, 0, 0);
    chk("lw_lat", lat, 2); chk("lw_data", mem_data_o, 32'hDEADBEEF);
    // aligned SH leaves captured read data alone
    access(ACCESS_OP_R2M, ACCESS_SZ_HALF, 32'h0000_1006, 32'h0000_5A5A, 0, 0, 0, 0);
    chk("sh_wd", cap_wd, 32'h5A5A5A5A); chk("sh_be", cap_be, 4'b1100);
    // misaligned stores
    access(ACCESS_OP_R2M, ACCESS_SZ_HALF, 32'h0000_1001, 32'h1234, 0, 0, 0, 0);
    chk("sh_aerr", cap_aerr, 1);
    access(ACCESS_OP_R2M, ACCESS_SZ_WORD, 32'h0000_1002, 32'h1234, 0, 0, 0, 0);
    chk("sw_aerr", cap_aerr, 1);
    // misaligned load
    access(ACCESS_OP_M2R, ACCESS_SZ_HALF, 32'h0000_1003, 0, 0, 0, 0, 0);
    chk("lh_aerr", cap_aerr, 1);
    // timeout: no ack
    access(ACCESS_OP_R2M, ACCESS_SZ_WORD, 32'h0000_0300, 32'h01020304, -1, 0, 0, 0);
    chk("to_lat", lat, TO + 1); chk("to_berr", cap_berr, 1); chk("to_data", mem_data_o, 0);
    // exception rising mid-access does not abort
    access(ACCESS_OP_M2R, ACCESS_SZ_HALF, 32'h0000_2002, 0, 1, 32'h12345678, 0, 1);
    chk("lh_exc_data", mem_data_o, 32'h12345678);
    // exception at issue, undefined size, non-bus op: no access
    access(ACCESS_OP_R2M, ACCESS_SZ_BYTE, 32'h0000_0010, 32'hFF, 0, 0, 1, 0);
    access(ACCESS_OP_R2M, 3'd5, 32'h0000_0010, 32'hFF, 0, 0, 0, 0);
    access(ACCESS_OP_M2R, 3'd7, 32'h0000_0011, 0, 0, 0, 0, 0);
    access(ACCESS_OP_REG, ACCESS_SZ_WORD, 32'h0000_0010, 32'hFF, 0, 0, 0, 0);
    // LB a=3
    access(ACCESS_OP_M2R, ACCESS_SZ_BYTE, 32'h0000_3003, 0, 0, 32'hCAFEF00D, 0, 0);

    // reset while BUSY
    req_valid = 1; mem_access_op = ACCESS_OP_R2M; mem_access_sz = ACCESS_SZ_WORD;
    addr_i = 32'h400; data_i = 32'h55; e_busy = 1;
    @(posedge clk); #1;
    cmp_en = 0;
    chk("pre_rst_write", dbus_write, 1);
    #2 rst = 1; req_valid = 0;
    #1;
    chk("rst_write", dbus_write, 0); chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0); chk("rst_be", dbus_byteenable, 0);
    @(posedge clk); #1 rst = 0;
    m_mdata = 0; idle_exp(); cmp_en = 1;
    @(posedge clk); #1;
    access(ACCESS_OP_R2M, ACCESS_SZ_BYTE, 32'h0000_0501, 32'h000000A7, 1, 0, 0, 0);
    chk("post_rst_wd", cap_wd, 32'hA7A7A7A7); chk("post_rst_be", cap_be, 4'b0010);
    chk("post_rst_lat", lat, 3);

    cmp_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
